// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package rf_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_ctrl_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } ll_entry_t;

  // Register 0 is hardwired; no write may ever target it.
  function automatic logic addr_writable(input logic [REG_ADDR_W-1:0] addr);
    return (addr != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order buffer for long-latency results; count, full and empty are registered.
module rf_wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  ll_entry_t push_entry,
  input  logic      pop,
  output ll_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ll_entry_t        mem_q [DEPTH];
  ll_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{addr: {REG_ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Next storage and pointer values; pointers wrap since DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Occupancy update; a simultaneous push and pop cancel out.
  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == {CNT_W{1'b0}});
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the 32x32 register file: optional post-reset clear
// sweep (RF_CLEAR_EN), writeback-first arbitration, long-latency FIFO, pend scoreboard.
module regfile_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int LL_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ll_valid,
  input  logic [REG_ADDR_W-1:0] ll_addr,
  input  logic [DATA_W-1:0]     ll_data,
  output logic                  ll_ready,
  input  logic                  ll_issue,
  input  logic [REG_ADDR_W-1:0] ll_issue_addr,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0]     rf_wd,
  output logic                  init_busy,
  output logic [NUM_REGS-1:0]   pend_mask
);

  rf_ctrl_state_t        state_s;
  logic [REG_ADDR_W-1:0] clr_addr_s;
  logic                  wb_eff_s;
  logic                  push_s;
  logic                  pop_s;
  ll_entry_t             head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [NUM_REGS-1:0]   pend_q, pend_d;

`ifdef RF_CLEAR_EN
  rf_ctrl_state_t        state_q, state_d;
  logic [REG_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // Sweep state and counter; the counter starts at 1 since register 0 needs no clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= REG_ADDR_W'(1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: leave CLEAR after the cycle that clears register 31.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + REG_ADDR_W'(1);
        if (clr_cnt_q == {REG_ADDR_W{1'b1}}) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign state_s    = state_q;
  assign clr_addr_s = clr_cnt_q;
  assign init_busy  = (state_q == CLEAR);
`else
  assign state_s    = RUN;
  assign clr_addr_s = {REG_ADDR_W{1'b0}};
  assign init_busy  = 1'b0;
`endif

  assign wb_eff_s = wb_we & addr_writable(wb_addr);
  assign ll_ready = ~rst & (state_s == RUN) & ~fifo_full_s;
  assign push_s   = ll_valid & ll_ready;

  // Write-port arbitration; outputs are forced quiet while reset is held.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = {REG_ADDR_W{1'b0}};
    rf_wd = {DATA_W{1'b0}};
    pop_s = 1'b0;
    if (rst) begin
      rf_we = 1'b0;
    end else begin
      case (state_s)
        CLEAR: begin
          rf_we = 1'b1;
          rf_wa = clr_addr_s;
          rf_wd = {DATA_W{1'b0}};
        end
        RUN: begin
          if (wb_eff_s) begin
            rf_we = 1'b1;
            rf_wa = wb_addr;
            rf_wd = wb_data;
          end else if (!fifo_empty_s) begin
            pop_s = 1'b1;
            rf_we = addr_writable(head_s.addr);
            rf_wa = head_s.addr;
            rf_wd = head_s.data;
          end else begin
            rf_we = 1'b0;
          end
        end
        default: rf_we = 1'b0;
      endcase
    end
  end

  rf_wb_fifo #(
    .DEPTH (LL_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry ('{addr: ll_addr, data: ll_data}),
    .pop        (pop_s),
    .head       (head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= {NUM_REGS{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

  // Clear on pop first so that a same-cycle issue to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (pop_s) begin
      pend_d[head_s.addr] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (ll_issue && addr_writable(ll_issue_addr)) begin
      pend_d[ll_issue_addr] = 1'b1;
    end else begin
      pend_d[0] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  assign pend_mask = pend_q;

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-port controller for the 32×32 register file. Sequences a post-reset clear sweep, then shares the single write port (`we3`/`wa3`/`wd3`) between two sources. The pipeline writeback stage has priority. The long-latency unit (divider / memory-miss return) is buffered in a 2-entry FIFO. The block also keeps a pending-write scoreboard that the hazard unit uses for stalls.

## Interface
Parameters:
- `LL_DEPTH`, 2: long-latency FIFO depth; power of two, ≥2.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wb_we` in 1: pipeline writeback enable; never back-pressured.
- `wb_addr` in 5: writeback destination.
- `wb_data` in 32: writeback data.
- `ll_valid` in 1: long-latency result valid.
- `ll_addr` in 5: long-latency destination.
- `ll_data` in 32: long-latency result.
- `ll_ready` out 1: FIFO can accept a result.
- `ll_issue` in 1: long-latency op issued this cycle.
- `ll_issue_addr` in 5: destination of the issued op.
- `rf_we` out 1: to regfile `we3`.
- `rf_wa` out 5: to regfile `wa3`.
- `rf_wd` out 32: to regfile `wd3`.
- `init_busy` out 1: clear sweep in progress; the pipeline must hold.
- `pend_mask` out 32: bit n set means register n has an outstanding long-latency write.

## Operation
- State machine has two states: CLEAR and RUN.
- Reset enters CLEAR with `clr_cnt`=1 (RUN if the clear feature is compiled out). Reset also empties the FIFO and sets `pend_mask`=0.
- CLEAR:
  - Drives `rf_we`=1, `rf_wa`=`clr_cnt`, `rf_wd`=0; `clr_cnt` increments each cycle.
  - After the cycle with `clr_cnt`=31, moves to RUN.
  - `wb_*` inputs are ignored and `ll_ready`=0.
- RUN, write-port arbitration (combinational from inputs and registered FIFO head):
  - A writeback is *effective* when `wb_we`=1 and `wb_addr`≠0.
  - Effective writeback: `rf_*` carries the `wb_*` values; the FIFO holds.
  - Otherwise, with the FIFO non-empty: `rf_*` carries the FIFO head, and the head pops at the clock edge.
  - Otherwise `rf_we`=0.
- Writes to address 0 are never forwarded. This applies to `wb` and to `ll` (an `ll` entry with addr 0 pops with `rf_we`=0).
- FIFO:
  - Push on `ll_valid & ll_ready`; `ll_ready` = RUN & count<`LL_DEPTH`, derived from registered count only.
  - Strict in-order pop.
  - Push and pop in the same cycle leave count unchanged.
- Scoreboard:
  - `ll_issue` with addr≠0 sets `pend_mask[ll_issue_addr]`.
  - A FIFO pop clears the bit for the head address.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.
- WAW and RAW safety is the hazard unit's duty: it stalls on `pend_mask`. The bench asserts that an effective `wb_addr` never has its pend bit set.

## Timing
- While `rst` is high: `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `ll_ready`=0, `pend_mask`=0. `init_busy` is 1 with the clear feature, 0 without.
- Clear sweep is exactly 31 cycles after `rst` deasserts. `init_busy` drops in the first RUN cycle.
- Writeback path has zero latency: combinational `wb_*` → `rf_*`, same cycle.
- `ll` path minimum latency is 1 cycle: a result accepted in cycle t is written in cycle t+1 at the earliest. It is delayed one cycle per effective writeback.
- `pend_mask` bit updates are visible the cycle after `ll_issue` or pop.
- Reset mid-sweep or mid-operation: the FIFO is flushed, results are lost, and the sweep restarts at 1.

## Configuration
- `RF_CLEAR_EN`:
  - Defined: the CLEAR sweep exists and all 31 registers read 0 after init.
  - Undefined: no CLEAR state, no counter, `init_busy` tied 0, reset goes straight to RUN, and regfile contents are undefined until written.

## Structure
- Shared package `rf_ctrl_pkg` holds:
  - `REG_ADDR_W`=5, `DATA_W`=32, `NUM_REGS`=32.
  - The `rf_ctrl_state_t` enum {CLEAR, RUN}.
  - A `ll_entry_t` struct {addr, data}.
- One sub-module, `rf_wb_fifo`: a `LL_DEPTH`-entry synchronous FIFO of `ll_entry_t` with registered count, full and empty.

## Test plan
- Reset, then idle 32 cycles → `rf_we`=1 for exactly 31 cycles with `rf_wa`=1..31 and `rf_wd`=0; `init_busy` falls at cycle 31.
- RUN, `wb_we`=1, `wb_addr`=5, `wb_data`=0xDEADBEEF → same-cycle `rf_we`=1, `rf_wa`=5, `rf_wd`=0xDEADBEEF. With `wb_addr`=0 → `rf_we`=0.
- `ll_issue` addr 9, then `ll_valid` addr 9 data 0x1234 while `wb_we` is held for 3 cycles to addr 3 → `pend_mask[9]`=1 throughout. Reg 9 is written on the first free cycle, and `pend_mask[9]` clears the next cycle.
- Two `ll` results back-to-back with `wb` busy → `ll_ready` drops to 0 after the second; both drain in order once `wb` stops.
- `ll_issue` to addr 7 in the same cycle a pop for addr 7 → `pend_mask[7]` remains 1.
- Assert `rst` with 2 FIFO entries and `pend_mask`=0x0000_0600 → FIFO empties, `pend_mask`=0, and the sweep restarts at `rf_wa`=1.
